alu_multicycle: RTL and testbench

Parametrised, clocked successor to the combinational ADDU datapath. It executes ADDU, SUBU, AND, OR, SRL and a multi-cycle unsigned multiply on WIDTH-bit operands behind a start/done handshake. Results are registered, and flags are added. It sits in the execute stage; the controller holds the pipeline while busy is high.

---
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_multicycle.sv | 133 +++++++++++++
 tb/tb_alu_multicycle.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the execute-stage controller and alu_multicycle.
// The controller owns start/opcode/operands; the ALU drives status and results.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       ALU_ctrl;
  logic [WIDTH-1:0] Src_1;
  logic [WIDTH-1:0] Src_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALU_Result;
  logic [WIDTH-1:0] ALU_Hi;
  logic             ALU_Carry;
  logic             ALU_Zero;

  modport master (
    output start, ALU_ctrl, Src_1, Src_2,
    input  busy, done, ALU_Result, ALU_Hi, ALU_Carry, ALU_Zero
  );

  modport slave (
    input  start, ALU_ctrl, Src_1, Src_2,
    output busy, done, ALU_Result, ALU_Hi, ALU_Carry, ALU_Zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle ADDU/SUBU/AND/OR/SRL and a WIDTH-cycle shift-add MULU.
// Results and flags are registered and change only on the cycle done is raised.
//
//   state  | meaning
//   S_IDLE | accepts start; single-cycle ops complete here in one edge
//   S_MUL  | one shift-add iteration per cycle, busy high, start ignored
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst,
  alu_multicycle_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [5:0] OP_ADDU = 6'b001001;
  localparam logic [5:0] OP_SUBU = 6'b001010;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SRL  = 6'b100010;
  localparam logic [5:0] OP_MULU = 6'b011001;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic               done_q, done_nxt;
  logic [WIDTH-1:0]   res_q, res_nxt;
  logic [WIDTH-1:0]   hi_q, hi_nxt;
  logic               carry_q, carry_nxt;
  logic               zero_q, zero_nxt;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mcand   <= mcand_nxt;
      mplier  <= mplier_nxt;
      acc     <= acc_nxt;
      done_q  <= done_nxt;
      res_q   <= res_nxt;
      hi_q    <= hi_nxt;
      carry_q <= carry_nxt;
      zero_q  <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    done_nxt   = 1'b0;
    res_nxt    = res_q;
    hi_nxt     = hi_q;
    carry_nxt  = carry_q;
    zero_nxt   = zero_q;

    sum  = {1'b0, bus.Src_1} + {1'b0, bus.Src_2};
    // Top bit of the widened difference is the unsigned borrow.
    diff = {1'b0, bus.Src_1} - {1'b0, bus.Src_2};
    step = acc + (mplier[0] ? mcand : '0);

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.ALU_ctrl == OP_MULU) begin
            mcand_nxt  = {{WIDTH{1'b0}}, bus.Src_1};
            mplier_nxt = bus.Src_2;
            acc_nxt    = '0;
            cnt_nxt    = CNT_W'(WIDTH);
            state_nxt  = S_MUL;
          end else begin
            done_nxt  = 1'b1;
            res_nxt   = '0;
            hi_nxt    = '0;
            carry_nxt = 1'b0;
            case (bus.ALU_ctrl)
              OP_ADDU: {carry_nxt, res_nxt} = sum;
              OP_SUBU: {carry_nxt, res_nxt} = diff;
              OP_AND:  res_nxt = bus.Src_1 & bus.Src_2;
              OP_OR:   res_nxt = bus.Src_1 | bus.Src_2;
              OP_SRL:  res_nxt = bus.Src_1 >> bus.Src_2[SH_W-1:0];
              default: res_nxt = '0;
            endcase
            zero_nxt = (res_nxt == '0);
          end
        end
      end
      S_MUL: begin
        acc_nxt    = step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt - CNT_W'(1);
        // Terminal count: this edge performs the final iteration.
        if (cnt == CNT_W'(1)) begin
          state_nxt          = S_IDLE;
          done_nxt           = 1'b1;
          {hi_nxt, res_nxt}  = step;
          carry_nxt          = 1'b0;
          zero_nxt           = (step == '0);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy       = (state == S_MUL);
  assign bus.done       = done_q;
  assign bus.ALU_Result = res_q;
  assign bus.ALU_Hi     = hi_q;
  assign bus.ALU_Carry  = carry_q;
  assign bus.ALU_Zero   = zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a WIDTH=32 instance for the main vectors
// and a WIDTH=8 instance for the narrow multiply.
module tb_alu_multicycle;
  localparam logic [5:0] OP_ADDU = 6'b001001;
  localparam logic [5:0] OP_SUBU = 6'b001010;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SRL  = 6'b100010;
  localparam logic [5:0] OP_MULU = 6'b011001;
  localparam logic [5:0] OP_BAD  = 6'b000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus ();
  alu_multicycle_if #(.WIDTH(8))  bus8 ();

  alu_multicycle #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_multicycle #(.WIDTH(8), .CNT_W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.ALU_ctrl = op;
    bus.Src_1    = a;
    bus.Src_2    = b;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic d, input logic [31:0] res,
                           input logic [31:0] hi, input logic c, input logic z);
    check({tag, "_done"},  64'(bus.done),       64'(d));
    check({tag, "_res"},   64'(bus.ALU_Result), 64'(res));
    check({tag, "_hi"},    64'(bus.ALU_Hi),     64'(hi));
    check({tag, "_carry"}, 64'(bus.ALU_Carry),  64'(c));
    check({tag, "_zero"},  64'(bus.ALU_Zero),   64'(z));
  endtask

  initial begin
    int bc;
    int dn;
    int extra;

    rst = 1'b1;
    bus.start = 1'b0; bus.ALU_ctrl = '0; bus.Src_1 = '0; bus.Src_2 = '0;
    bus8.start = 1'b0; bus8.ALU_ctrl = '0; bus8.Src_1 = '0; bus8.Src_2 = '0;
    tick; tick;
    check_out("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    tick;

    drive(OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0001);
    check_out("addu_carry", 1'b1, 32'h0, 32'h0, 1'b1, 1'b1);
    tick;
    check("addu_done_drop", 64'(bus.done), 64'd0);
    check("addu_hold", 64'(bus.ALU_Carry), 64'd1);

    drive(OP_ADDU, 32'd5, 32'd7);
    check_out("addu", 1'b1, 32'd12, 32'h0, 1'b0, 1'b0);
    drive(OP_SUBU, 32'd3, 32'd5);
    check_out("subu", 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0);
    drive(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
    check_out("and", 1'b1, 32'h0000_00F0, 32'h0, 1'b0, 1'b0);
    drive(OP_OR, 32'h0000_F0F0, 32'h0000_0FF0);
    check_out("or", 1'b1, 32'h0000_FFF0, 32'h0, 1'b0, 1'b0);
    drive(OP_SRL, 32'h8000_0000, 32'd31);
    check_out("srl", 1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
    tick;

    // MULU with operand churn and a stray start while busy.
    drive(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_first_done", 64'(bus.done), 64'd0);
    bc = 0; dn = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        dn++;
        break;
      end
      if (bus.busy) bc++;
      bus.Src_1    = ~bus.Src_1;
      bus.Src_2    = bus.Src_2 ^ 32'h1234_5678;
      bus.start    = (i == 5);
      bus.ALU_ctrl = (i == 5) ? OP_ADDU : OP_MULU;
      tick;
    end
    bus.start = 1'b0;
    check("mul_done_seen", 64'(dn), 64'd1);
    check("mul_busy_cycles", 64'(bc), 64'd32);
    check("mul_busy_at_done", 64'(bus.busy), 64'd0);
    check_out("mul", 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    extra = 0;
    repeat (3) begin
      tick;
      if (bus.done) extra++;
    end
    check("mul_single_done", 64'(extra), 64'd0);
    check("mul_hold_hi", 64'(bus.ALU_Hi), 64'hFFFF_FFFE);

    // Back-to-back with start held high.
    bus.start = 1'b1;
    bus.ALU_ctrl = OP_ADDU; bus.Src_1 = 32'd5; bus.Src_2 = 32'd7;
    tick;
    check_out("b2b_addu", 1'b1, 32'd12, 32'h0, 1'b0, 1'b0);
    bus.ALU_ctrl = OP_SUBU; bus.Src_1 = 32'd3; bus.Src_2 = 32'd5;
    tick;
    check_out("b2b_subu", 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0);
    bus.ALU_ctrl = OP_AND; bus.Src_1 = 32'h0000_F0F0; bus.Src_2 = 32'h0000_0FF0;
    tick;
    check_out("b2b_and", 1'b1, 32'h0000_00F0, 32'h0, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick;
    check("b2b_done_drop", 64'(bus.done), 64'd0);

    drive(OP_BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_out("illegal", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);

    // Reset in the middle of a multiply.
    drive(OP_ADDU, 32'd5, 32'd7);
    drive(OP_MULU, 32'hFFFF_FFFF, 32'd2);
    repeat (10) tick;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check_out("mid_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    tick; tick;
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      tick;
      if (bus.done) dn++;
    end
    check("post_rst_no_done", 64'(dn), 64'd0);
    drive(OP_ADDU, 32'd1, 32'd1);
    check_out("post_rst_addu", 1'b1, 32'd2, 32'h0, 1'b0, 1'b0);

    // Narrow build multiply.
    bus8.start = 1'b1; bus8.ALU_ctrl = OP_MULU; bus8.Src_1 = 8'hFF; bus8.Src_2 = 8'hFF;
    tick;
    bus8.start = 1'b0;
    bc = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.done) begin
        dn++;
        break;
      end
      if (bus8.busy) bc++;
      tick;
    end
    check("mul8_done_seen", 64'(dn), 64'd1);
    check("mul8_busy_cycles", 64'(bc), 64'd8);
    check("mul8_hi", 64'(bus8.ALU_Hi), 64'h0FE);
    check("mul8_res", 64'(bus8.ALU_Result), 64'h001);
    check("mul8_zero", 64'(bus8.ALU_Zero), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
